key_press_decoder: RTL
======================

KEY_PRESS_DECODER -- requirements
Module: key_press_decoder

Interface
REQ-001 Parameter CNT_LONG, default 26'd49_999_999: hold time for a long press, 1 s at 50 MHz, in sys_clk cycles minus one.
REQ-002 Parameter CNT_DBL, default 26'd12_499_999: gap window for a second press, 250 ms at 50 MHz, in cycles minus one; CNT_DBL < CNT_LONG.
REQ-003 sys_clk  input  1  single system clock; all logic on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_in  input  1  debounced key level, already in sys_clk domain; 0 = pressed, 1 = released.
REQ-006 short_press  output  1  one-cycle pulse: single press shorter than long threshold, no second press in window.
REQ-007 long_press  output  1  one-cycle pulse: first press held to long threshold.
REQ-008 double_press  output  1  one-cycle pulse: second press completed inside gap window.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 key_in shall be registered once (key_d); press edge = key_d==1 & key_in==0; release edge = key_d==0 & key_in==1.
REQ-011 A 26-bit counter cnt shall be cleared on every state change and otherwise increment by 1 per cycle, saturating at its compare value.
REQ-012 FSM states: IDLE, PRESS1, WAIT2, PRESS2, HOLD.
REQ-013 IDLE: press edge -> PRESS1; all else stay.
REQ-014 PRESS1: cnt==CNT_LONG with key_in==0 -> HOLD and pulse long_press; release edge before that -> WAIT2.
REQ-015 PRESS1 boundary: release edge in the same cycle as cnt==CNT_LONG -> long wins: HOLD, long_press; HOLD then exits on the already-released level.
REQ-016 HOLD: key_in==1 -> IDLE with no pulse; no further pulses while held.
REQ-017 WAIT2: press edge -> PRESS2; cnt==CNT_DBL with no press edge -> IDLE and pulse short_press.
REQ-018 WAIT2 boundary: press edge in the same cycle as cnt==CNT_DBL -> press wins: PRESS2, no short_press.
REQ-019 PRESS2: release edge -> IDLE and pulse double_press, regardless of second-press duration; cnt unused.
REQ-020 All three pulse outputs shall be registered: high exactly one cycle, in the cycle after the clock edge on which the deciding transition is taken.
REQ-021 At most one of short_press, long_press, double_press shall be high in any cycle; one gesture shall produce exactly one pulse, except a long press, which produces long_press only.
REQ-022 busy shall be registered from next-state: high from the cycle after the press edge until the cycle after return to IDLE.

Reset
REQ-023 On sys_rst_n==0, immediately and asynchronously: state=IDLE, cnt=0, key_d=1, short_press=long_press=double_press=busy=0.
REQ-024 Reset asserted mid-gesture shall discard the gesture: no pulse during or after reset.
REQ-025 After release of reset, a key already held (key_in==0) shall not count as a press until a release then a new press edge occurs.

Verification (CNT_LONG=26'd99, CNT_DBL=26'd29)
REQ-026 Short: key_in low 20 cycles, then high -> exactly one short_press, 30 cycles after release edge (+1 register); no other pulse.
REQ-027 Long: key_in low 150 cycles -> long_press once, 100 cycles after press edge (+1); no pulse at release; busy falls after release.
REQ-028 Double: low 10, high 10, low 10, high -> one double_press the cycle after second release; no short_press.
REQ-029 Boundaries: release exactly at cnt==99 in PRESS1 -> long_press; second press exactly at cnt==29 in WAIT2 -> double_press, no short_press.
REQ-030 Reset: assert sys_rst_n=0 during WAIT2, release with key_in held low -> no pulses; state IDLE until a release then a new press.
REQ-031 Idle stability: key_in held high 1000 cycles after reset -> all outputs remain 0.

Source files
------------

// File: rtl/key_press_decoder_if.sv
// rtl/key_press_decoder_if.sv - key level in, gesture pulses and busy out
// Groups the key input and the decoded gesture outputs of key_press_decoder.
interface key_press_decoder_if;
   logic key_in;
   logic short_press;
   logic long_press;
   logic double_press;
   logic busy;

   modport master (
      output key_in,
      input  short_press,
      input  long_press,
      input  double_press,
      input  busy
   );

   modport slave (
      input  key_in,
      output short_press,
      output long_press,
      output double_press,
      output busy
   );
endinterface

// File: rtl/key_press_decoder.sv
// rtl/key_press_decoder.sv - single-key short/long/double press gesture decoder
// Turns a debounced active-low key level into one registered pulse per gesture.
module key_press_decoder #(
   parameter logic [25:0] CNT_LONG = 26'd49_999_999,
   parameter logic [25:0] CNT_DBL  = 26'd12_499_999
) (
   input logic             sys_clk,
   input logic             sys_rst_n,
   key_press_decoder_if.slave kp
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      WAIT2  = 3'd2,
      PRESS2 = 3'd3,
      HOLD   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [25:0] cnt_q, cnt_d, cnt_lim;
   logic        key_q;
   logic        arm_q;
   logic        short_q, short_d;
   logic        long_q, long_d;
   logic        dbl_q, dbl_d;
   logic        busy_q;
   logic        press_edge;
   logic        release_edge;

   // arm_q blocks a key that was already held when reset was released
   assign press_edge   = arm_q & key_q & ~kp.key_in;
   assign release_edge = ~key_q & kp.key_in;

   always_comb begin
      state_d = state_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      dbl_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (press_edge) state_d = PRESS1;
         end
         PRESS1: begin
            // reaching the long threshold outranks a simultaneous release
            if (cnt_q == CNT_LONG) begin
               state_d = HOLD;
               long_d  = 1'b1;
            end else if (release_edge) begin
               state_d = WAIT2;
            end
         end
         WAIT2: begin
            if (press_edge) begin
               state_d = PRESS2;
            end else if (cnt_q == CNT_DBL) begin
               state_d = IDLE;
               short_d = 1'b1;
            end
         end
         PRESS2: begin
            if (release_edge) begin
               state_d = IDLE;
               dbl_d   = 1'b1;
            end
         end
         HOLD: begin
            if (kp.key_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_lim = '0;
      unique case (state_q)
         PRESS1:  cnt_lim = CNT_LONG;
         WAIT2:   cnt_lim = CNT_DBL;
         default: cnt_lim = '0;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q < cnt_lim) begin
         cnt_d = cnt_q + 26'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         key_q   <= 1'b1;
         arm_q   <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         dbl_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= kp.key_in;
         arm_q   <= arm_q | kp.key_in;
         short_q <= short_d;
         long_q  <= long_d;
         dbl_q   <= dbl_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign kp.short_press  = short_q;
   assign kp.long_press   = long_q;
   assign kp.double_press = dbl_q;
   assign kp.busy         = busy_q;

endmodule
